// File: rtl/tmr_triplet_lock_arbiter.sv
// Round-robin arbiter in front of the time-TMR voter: a winner keeps the grant
// for one full redundant triplet, with timeout release, voter extension and flush.
module tmr_triplet_lock_arbiter #(
  parameter int unsigned NumIn       = 3,
  parameter type         DataType    = logic,
  parameter int unsigned LockTimeout = 5,
  parameter int unsigned IdxWidth    = $clog2(NumIn)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [NumIn-1:0]    req_i,
  output logic [NumIn-1:0]    gnt_o,
  input  DataType             data_i [NumIn],
  output logic                req_o,
  input  logic                gnt_i,
  output DataType             data_o,
  output logic [IdxWidth-1:0] idx_o,
  input  logic                lock_i,
  output logic                locked_o,
  output logic                timeout_o
);

  localparam int unsigned TmrWidth = $clog2(LockTimeout + 1);
  localparam logic [TmrWidth-1:0] TmrMax  = TmrWidth'(LockTimeout - 1);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state;
  logic [IdxWidth-1:0] ptr;
  logic [IdxWidth-1:0] lk_idx;
  logic [1:0]          cnt;
  logic [TmrWidth-1:0] tmr;
  logic                hold_v;
  logic [IdxWidth-1:0] hold_idx;
  logic                timeout_q;

  logic [IdxWidth-1:0] rr_sel;
  logic [IdxWidth-1:0] sel;
  logic [IdxWidth-1:0] nxt_ptr;
  logic [1:0]          cnt_inc;
  logic                found;
  int unsigned         cand;
  logic                xfer;

  // First asserted request at or after ptr, wrapping modulo NumIn.
  always_comb begin
    rr_sel = ptr;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      cand = (32'(ptr) + i) % NumIn;
      if (!found && req_i[IdxWidth'(cand)]) begin
        found  = 1'b1;
        rr_sel = IdxWidth'(cand);
      end
    end
  end

  // A stalled offer keeps its index; otherwise the lock owner, else round-robin.
  always_comb begin
    if (hold_v)               sel = hold_idx;
    else if (state == LOCKED) sel = lk_idx;
    else                      sel = rr_sel;
  end

  always_comb begin
    gnt_o      = '0;
    gnt_o[sel] = ~rst_i & gnt_i & req_i[sel];
  end

  assign req_o     = ~rst_i & req_i[sel];
  assign data_o    = data_i[sel];
  assign idx_o     = sel;
  assign xfer      = req_o & gnt_i;
  assign nxt_ptr   = (lk_idx == LastIdx) ? '0 : lk_idx + IdxWidth'(1);
  assign cnt_inc   = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
  assign locked_o  = (state == LOCKED);
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state     <= IDLE;
      ptr       <= '0;
      lk_idx    <= '0;
      cnt       <= '0;
      tmr       <= '0;
      hold_v    <= 1'b0;
      hold_idx  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      hold_v    <= req_o & ~gnt_i;
      hold_idx  <= sel;
      case (state)
        IDLE: begin
          if (xfer) begin
            state  <= LOCKED;
            lk_idx <= sel;
            cnt    <= 2'd1;
            tmr    <= '0;
          end
        end
        LOCKED: begin
          if (xfer) begin
            tmr <= '0;
            if (cnt_inc == 2'd3 && !lock_i) begin
              state <= IDLE;
              ptr   <= nxt_ptr;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end else if (cnt == 2'd3 && !lock_i) begin
            // Extension just dropped: release without a timeout pulse.
            state <= IDLE;
            ptr   <= nxt_ptr;
            cnt   <= '0;
            tmr   <= '0;
          end else if (tmr == TmrMax) begin
            state     <= IDLE;
            ptr       <= nxt_ptr;
            cnt       <= '0;
            tmr       <= '0;
            timeout_q <= 1'b1;
          end else begin
            tmr <= tmr + TmrWidth'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_triplet_lock_arbiter.sv
// Directed bench for tmr_triplet_lock_arbiter (NumIn=3, LockTimeout=5, 8-bit payload).
module tb_tmr_triplet_lock_arbiter;

  logic       clk = 1'b0;
  logic       rst_i, flush_i, gnt_i, lock_i;
  logic [2:0] req_i;
  logic [2:0] gnt_o;
  logic [7:0] data_i [3];
  logic       req_o;
  logic [7:0] data_o;
  logic [1:0] idx_o;
  logic       locked_o, timeout_o;

  int checks = 0;
  int errors = 0;

  tmr_triplet_lock_arbiter #(
    .NumIn(3), .DataType(logic [7:0]), .LockTimeout(5)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_i(req_i), .gnt_o(gnt_o), .data_i(data_i),
    .req_o(req_o), .gnt_i(gnt_i), .data_o(data_o), .idx_o(idx_o),
    .lock_i(lock_i), .locked_o(locked_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; flush_i = 1'b0; req_i = '0; gnt_i = 1'b0; lock_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; lock_i = 1'b0; req_i = 3'b111; gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_o, gnt_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got req=%b gnt=%b expected 0/000", req_o, gnt_o);
    end
    rst_i = 1'b0; gnt_i = 1'b0;
    #1;
    checks++;
    if ({locked_o, timeout_o, idx_o} !== {1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL reset_state: got locked=%b timeout=%b idx=%0d expected 0 0 0",
                         locked_o, timeout_o, idx_o);
    end
    checks++;
    if (data_o !== 8'hA0) begin
      errors++; $display("FAIL reset_data: got %h expected a0", data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e_idx;
    logic [2:0] e_gnt;
    logic       e_lk;
    do_reset();
    req_i = 3'b111; gnt_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      e_idx = 2'((c / 3) % 3);
      e_gnt = 3'b001 << e_idx;
      e_lk  = (c % 3) != 0;
      #1;
      checks++;
      if (idx_o !== e_idx) begin
        errors++; $display("FAIL b2b_idx c%0d: got %0d expected %0d", c, idx_o, e_idx);
      end
      checks++;
      if (gnt_o !== e_gnt) begin
        errors++; $display("FAIL b2b_gnt c%0d: got %b expected %b", c, gnt_o, e_gnt);
      end
      checks++;
      if (locked_o !== e_lk) begin
        errors++; $display("FAIL b2b_locked c%0d: got %b expected %b", c, locked_o, e_lk);
      end
      @(negedge clk);
    end
    req_i = '0; gnt_i = 1'b0;
  endtask

  task automatic test_lock_exclusivity();
    do_reset();
    req_i = 3'b001; gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 3'b001) begin
      errors++; $display("FAIL excl_first_gnt: got %b expected 001", gnt_o);
    end
    @(negedge clk);
    req_i = 3'b110;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({req_o, gnt_o} !== 4'b0000) begin
        errors++; $display("FAIL excl_blocked k%0d: got req=%b gnt=%b expected 0/000", k, req_o, gnt_o);
      end
      checks++;
      if ({locked_o, timeout_o} !== 2'b10) begin
        errors++; $display("FAIL excl_hold k%0d: got locked=%b timeout=%b expected 1 0",
                           k, locked_o, timeout_o);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({timeout_o, locked_o, idx_o} !== {1'b1, 1'b0, 2'd1}) begin
      errors++; $display("FAIL excl_timeout: got timeout=%b locked=%b idx=%0d expected 1 0 1",
                         timeout_o, locked_o, idx_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({timeout_o, locked_o, idx_o} !== {1'b0, 1'b1, 2'd1}) begin
      errors++; $display("FAIL excl_after: got timeout=%b locked=%b idx=%0d expected 0 1 1",
                         timeout_o, locked_o, idx_o);
    end
    req_i = '0; gnt_i = 1'b0;
  endtask

  task automatic test_timeout_race();
    do_reset();
    req_i = 3'b001; gnt_i = 1'b1;
    @(negedge clk);
    req_i = 3'b000;
    repeat (4) @(negedge clk);
    req_i = 3'b001;
    #1;
    checks++;
    if (gnt_o !== 3'b001) begin
      errors++; $display("FAIL race_gnt: got %b expected 001", gnt_o);
    end
    @(negedge clk);
    req_i = 3'b000;
    #1;
    checks++;
    if ({locked_o, timeout_o} !== 2'b10) begin
      errors++; $display("FAIL race_no_timeout: got locked=%b timeout=%b expected 1 0",
                         locked_o, timeout_o);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if ({locked_o, timeout_o} !== 2'b01) begin
      errors++; $display("FAIL race_late_timeout: got locked=%b timeout=%b expected 0 1",
                         locked_o, timeout_o);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    req_i = 3'b001; gnt_i = 1'b1;
    repeat (3) @(negedge clk);
    req_i = 3'b011; gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({idx_o, data_o} !== {2'd1, 8'hA1}) begin
        errors++; $display("FAIL stall_sel k%0d: got idx=%0d data=%h expected 1 a1", k, idx_o, data_o);
      end
      checks++;
      if ({req_o, gnt_o} !== 4'b1000) begin
        errors++; $display("FAIL stall_hs k%0d: got req=%b gnt=%b expected 1/000", k, req_o, gnt_o);
      end
      @(negedge clk);
    end
    gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 3'b010) begin
      errors++; $display("FAIL stall_release: got %b expected 010", gnt_o);
    end
    @(negedge clk);
    req_i = 3'b001;
    #1;
    checks++;
    if ({gnt_o, idx_o, locked_o} !== {3'b000, 2'd1, 1'b1}) begin
      errors++; $display("FAIL stall_single: got gnt=%b idx=%0d locked=%b expected 000 1 1",
                         gnt_o, idx_o, locked_o);
    end
    // Held index must survive a request pattern that would re-arbitrate elsewhere.
    do_reset();
    req_i = 3'b010; gnt_i = 1'b1;
    repeat (3) @(negedge clk);
    req_i = 3'b011; gnt_i = 1'b0;
    #1;
    checks++;
    if (idx_o !== 2'd0) begin
      errors++; $display("FAIL hold_first: got idx=%0d expected 0", idx_o);
    end
    @(negedge clk);
    req_i = 3'b111;
    #1;
    checks++;
    if ({idx_o, data_o} !== {2'd0, 8'hA0}) begin
      errors++; $display("FAIL hold_stable: got idx=%0d data=%h expected 0 a0", idx_o, data_o);
    end
    gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 3'b001) begin
      errors++; $display("FAIL hold_gnt: got %b expected 001", gnt_o);
    end
    @(negedge clk);
    req_i = '0; gnt_i = 1'b0;
  endtask

  task automatic test_lock_extension();
    do_reset();
    gnt_i = 1'b1; req_i = 3'b100;
    for (int t = 0; t < 5; t++) begin
      lock_i = (t >= 2);
      #1;
      checks++;
      if ({idx_o, gnt_o} !== {2'd2, 3'b100}) begin
        errors++; $display("FAIL ext_xfer t%0d: got idx=%0d gnt=%b expected 2 100", t, idx_o, gnt_o);
      end
      @(negedge clk);
      req_i = 3'b111;
    end
    lock_i = 1'b0; req_i = 3'b000;
    #1;
    checks++;
    if (locked_o !== 1'b1) begin
      errors++; $display("FAIL ext_still_locked: got %b expected 1", locked_o);
    end
    @(negedge clk);
    req_i = 3'b111;
    #1;
    checks++;
    if ({locked_o, timeout_o, idx_o} !== {1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL ext_release: got locked=%b timeout=%b idx=%0d expected 0 0 0",
                         locked_o, timeout_o, idx_o);
    end
    req_i = '0; gnt_i = 1'b0;
  endtask

  task automatic test_flush_mid_lock();
    do_reset();
    req_i = 3'b010; gnt_i = 1'b1;
    repeat (2) @(negedge clk);
    flush_i = 1'b1; req_i = '0; gnt_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0; req_i = 3'b111;
    #1;
    checks++;
    if ({locked_o, timeout_o, idx_o} !== {1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL flush_state: got locked=%b timeout=%b idx=%0d expected 0 0 0",
                         locked_o, timeout_o, idx_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    req_i = 3'b100; gnt_i = 1'b1;
    @(negedge clk);
    req_i = 3'b111; gnt_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({idx_o, gnt_o} !== {2'd2, 3'b000}) begin
      errors++; $display("FAIL rststall_pre: got idx=%0d gnt=%b expected 2 000", idx_o, gnt_o);
    end
    @(negedge clk);
    rst_i = 1'b1; gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({req_o, gnt_o} !== 4'b0000) begin
        errors++; $display("FAIL rststall_force k%0d: got req=%b gnt=%b expected 0/000", k, req_o, gnt_o);
      end
      @(negedge clk);
    end
    rst_i = 1'b0; gnt_i = 1'b0;
    #1;
    checks++;
    if ({locked_o, timeout_o, idx_o, req_o} !== {1'b0, 1'b0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL rststall_post: got locked=%b timeout=%b idx=%0d req=%b expected 0 0 0 1",
                         locked_o, timeout_o, idx_o, req_o);
    end
    checks++;
    if (data_o !== 8'hA0) begin
      errors++; $display("FAIL rststall_data: got %h expected a0", data_o);
    end
  endtask

  initial begin
    data_i = '{8'hA0, 8'hA1, 8'hA2};
    test_reset();
    test_back_to_back();
    test_lock_exclusivity();
    test_timeout_race();
    test_stall_hold();
    test_lock_extension();
    test_flush_mid_lock();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
